fir_filter_tdm: RTL and testbench

FIR_FILTER_TDM -- requirements
Module: fir_filter_tdm

---
 rtl/fir_pkg.sv | 15 +
 rtl/fir_mac.sv | 42 ++++
 rtl/fir_filter_tdm.sv | 155 +++++++++++++++
 tb/tb_fir_filter_tdm.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FSM state encoding and accumulator width helper for the TDM FIR.
package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_HOLD = 2'd2
   } fir_state_e;

   // Wide enough to sum TAPS full-scale products without overflow.
   function automatic int acc_w(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_mac.sv
// Single multiplier plus accumulator: one signed product added per enabled cycle.
// Clear wins over enable; the accumulator is only read when the caller says so.
module fir_mac #(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = 35
) (
   input  logic                     clk,
   input  logic                     i_rst_n,
   input  logic                     i_clr,
   input  logic                     i_en,
   input  logic signed [COEF_W-1:0] i_coef,
   input  logic signed [DATA_W-1:0] i_smp,
   output logic signed [ACC_W-1:0]  o_acc
);

   localparam int PROD_W = DATA_W + COEF_W;

   logic signed [PROD_W-1:0] w_coef_ext;
   logic signed [PROD_W-1:0] w_smp_ext;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  r_acc;

   assign w_coef_ext = {{DATA_W{i_coef[COEF_W-1]}}, i_coef};
   assign w_smp_ext  = {{COEF_W{i_smp[DATA_W-1]}}, i_smp};
   assign w_prod     = w_coef_ext * w_smp_ext;
   assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc <= '0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= r_acc + w_prod_ext;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/fir_filter_tdm.sv
// Time-multiplexed FIR: one sample accepted per TAPS+2 cycles, result held until out_ready.
// in_ready only while idle; coefficient writes are accepted only while idle.
module fir_filter_tdm
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int TAPS   = 8,
   parameter int OUT_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       coef_we,
   input  logic [$clog2(TAPS)-1:0]    coef_addr,
   input  logic signed [COEF_W-1:0]   coef_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W-1:0]   x_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUT_W-1:0]    y_out,
   output logic                       sat_flag
);

   localparam int AW    = $clog2(TAPS);
   localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);

   fir_state_e r_state;
   fir_state_e w_state_nxt;

   logic signed [DATA_W-1:0] r_x [TAPS];
   logic signed [COEF_W-1:0] r_h [TAPS];
   logic [AW-1:0]            r_cnt;
   logic                     r_pend_vld;
   logic [AW-1:0]            r_pend_addr;
   logic signed [COEF_W-1:0] r_pend_dat;

   logic                     w_accept;
   logic                     w_addr_ok;
   logic                     w_last;
   logic                     w_mac_en;
   logic                     w_release;
   logic signed [ACC_W-1:0]  w_acc;
   logic signed [OUT_W-1:0]  w_y;
   logic                     w_sat;

   assign w_accept  = (r_state == ST_IDLE) && in_valid;
   assign w_addr_ok = int'(coef_addr) < TAPS;
   assign w_last    = (r_cnt == AW'(TAPS-1));
   assign w_mac_en  = (r_state == ST_MAC);
   assign w_release = (r_state == ST_HOLD) && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)  w_state_nxt = ST_MAC;
         ST_MAC:  if (w_last)    w_state_nxt = ST_HOLD;
         ST_HOLD: if (out_ready) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_HOLD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if (w_mac_en && !w_last) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TAPS; i++) r_x[i] <= '0;
      end else if (w_accept) begin
         r_x[0] <= x_in;
         for (int i = 1; i < TAPS; i++) r_x[i] <= r_x[i-1];
      end
   end

   // A write that lands with an accepted sample is parked until the result
   // is released, so it cannot disturb the sample already in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend_vld  <= 1'b0;
         r_pend_addr <= '0;
         r_pend_dat  <= '0;
      end else if (w_accept && coef_we && w_addr_ok) begin
         r_pend_vld  <= 1'b1;
         r_pend_addr <= coef_addr;
         r_pend_dat  <= coef_data;
      end else if (w_release) begin
         r_pend_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TAPS; i++) r_h[i] <= COEF_W'(1);
      end else if (w_release && r_pend_vld) begin
         r_h[r_pend_addr] <= r_pend_dat;
      end else if ((r_state == ST_IDLE) && !in_valid && coef_we && w_addr_ok) begin
         r_h[coef_addr] <= coef_data;
      end
   end

   fir_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk     (clk),
      .i_rst_n (reset),
      .i_clr   (w_accept),
      .i_en    (w_mac_en),
      .i_coef  (r_h[r_cnt]),
      .i_smp   (r_x[r_cnt]),
      .o_acc   (w_acc)
   );

   generate
      if (OUT_W < ACC_W) begin : g_sat
         // Fits when every bit above the output sign bit matches it.
         logic [ACC_W-OUT_W:0] w_hi;
         logic                 w_fits;
         assign w_hi   = w_acc[ACC_W-1:OUT_W-1];
         assign w_fits = (&w_hi) | ~(|w_hi);
         assign w_y    = w_fits ? w_acc[OUT_W-1:0]
                                : {w_acc[ACC_W-1], {(OUT_W-1){~w_acc[ACC_W-1]}}};
         assign w_sat  = ~w_fits;
      end else if (OUT_W == ACC_W) begin : g_pass
         assign w_y   = w_acc;
         assign w_sat = 1'b0;
      end else begin : g_ext
         assign w_y   = {{(OUT_W-ACC_W){w_acc[ACC_W-1]}}, w_acc};
         assign w_sat = 1'b0;
      end
   endgenerate

   assign y_out    = w_y;
   assign sat_flag = w_sat;

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Directed bench: two DUTs (32-bit and 16-bit output) share stimulus; a model fills a scoreboard.
module tb_fir_filter_tdm;

   localparam int TAPS = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        coef_we;
   logic [2:0]  coef_addr;
   logic [15:0] coef_data;
   logic        in_valid;
   logic [15:0] x_in;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, sat_a;
   logic [31:0] y_a;
   logic        in_ready_b, out_valid_b, sat_b;
   logic [15:0] y_b;

   always #5 clk = ~clk;

   fir_filter_tdm #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(32)) dut_a (
      .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready_a),
      .x_in(x_in), .out_valid(out_valid_a), .out_ready(out_ready),
      .y_out(y_a), .sat_flag(sat_a)
   );

   fir_filter_tdm #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_W(16)) dut_b (
      .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready_b),
      .x_in(x_in), .out_valid(out_valid_b), .out_ready(out_ready),
      .y_out(y_b), .sat_flag(sat_b)
   );

   typedef struct {
      logic [31:0] y32;
      logic        s32;
      logic [15:0] y16;
      logic        s16;
   } exp_t;

   exp_t   sb[$];
   int     m_h[TAPS];
   longint m_x[TAPS];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic satw(input longint v, input int w, output longint y, output logic s);
      longint mx, mn;
      mx = (longint'(1) << (w-1)) - 1;
      mn = -mx - 1;
      s  = 1'b0;
      y  = v;
      if (v > mx) begin y = mx; s = 1'b1; end
      if (v < mn) begin y = mn; s = 1'b1; end
   endtask

   task automatic model_reset();
      for (int i = 0; i < TAPS; i++) begin
         m_h[i] = 1;
         m_x[i] = 0;
      end
      sb.delete();
   endtask

   task automatic model_accept(input int x);
      longint sum, y;
      logic   s;
      exp_t   e;
      for (int i = TAPS-1; i > 0; i--) m_x[i] = m_x[i-1];
      m_x[0] = x;
      sum = 0;
      for (int k = 0; k < TAPS; k++) sum += longint'(m_h[k]) * m_x[k];
      satw(sum, 32, y, s);
      e.y32 = y[31:0];
      e.s32 = s;
      satw(sum, 16, y, s);
      e.y16 = y[15:0];
      e.s16 = s;
      sb.push_back(e);
   endtask

   task automatic idle_write(input int a, input int d);
      logic [31:0] dv;
      dv        = d;
      coef_we   = 1'b1;
      coef_addr = a[2:0];
      coef_data = dv[15:0];
      @(posedge clk);
      #1;
      coef_we   = 1'b0;
      m_h[a]    = d;
   endtask

   task automatic send(input int x, input bit wr, input int wa, input int wd, output int acc_c);
      int n;
      logic [31:0] xv, dv;
      n = 0;
      while (!(in_ready_a && in_ready_b) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_ready", {in_ready_a, in_ready_b}, 2'b11);
      xv        = x;
      dv        = wd;
      in_valid  = 1'b1;
      x_in      = xv[15:0];
      coef_we   = wr;
      coef_addr = wa[2:0];
      coef_data = dv[15:0];
      @(posedge clk);
      model_accept(x);
      if (wr) m_h[wa] = wd;
      #1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      acc_c    = cyc;
   endtask

   task automatic collect(input int acc_c, input int stall);
      int   n;
      exp_t e;
      n = 0;
      while (!out_valid_a && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("valid_seen", {out_valid_a, out_valid_b}, 2'b11);
      // Counting the accept cycle as the first one.
      chk("latency", cyc - acc_c + 1, TAPS + 1);
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("y32", y_a, e.y32);
         chk("sat32", sat_a, e.s32);
         chk("y16", y_b, e.y16);
         chk("sat16", sat_b, e.s16);
         for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid_a, 1);
            chk("stall_y", y_a, e.y32);
            chk("stall_in_ready", in_ready_a, 0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("released", {out_valid_a, out_valid_b}, 2'b00);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      chk("rst_out_valid", {out_valid_a, out_valid_b}, 2'b00);
      chk("rst_in_ready", {in_ready_a, in_ready_b}, 2'b11);
      chk("rst_y", {y_a, y_b}, 48'd0);
      chk("rst_sat", {sat_a, sat_b}, 2'b00);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int a, prev, seen;
      reset     = 1'b0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      in_valid  = 1'b0;
      x_in      = '0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // Moving sum over the default coefficients, back to back.
      prev = 0;
      for (int i = 1; i <= 6; i++) begin
         send(i, 0, 0, 0, a);
         if (i > 1) chk("throughput", a - prev, TAPS + 2);
         prev = a;
         collect(a, 0);
      end

      // A write during MAC must be dropped.
      send(7, 0, 0, 0, a);
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 16'd5;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
      collect(a, 0);
      send(8, 0, 0, 0, a);
      collect(a, 0);

      // Downstream stall in HOLD, then the following sample.
      out_ready = 1'b0;
      send(9, 0, 0, 0, a);
      collect(a, 5);
      send(10, 0, 0, 0, a);
      collect(a, 0);

      // Reset in the middle of MAC: nothing comes out, history is cleared.
      send(11, 0, 0, 0, a);
      repeat (3) @(posedge clk);
      #1;
      do_reset();
      seen = 0;
      for (int i = 0; i < TAPS + 3; i++) begin
         @(posedge clk);
         #1;
         if (out_valid_a || out_valid_b) seen++;
      end
      chk("no_output_after_reset", seen, 0);
      send(50, 0, 0, 0, a);
      collect(a, 0);

      // Difference filter h = {1,-1,0,...} on an impulse.
      do_reset();
      idle_write(1, -1);
      for (int k = 2; k < TAPS; k++) idle_write(k, 0);
      send(100, 0, 0, 0, a); collect(a, 0);
      send(0, 0, 0, 0, a);   collect(a, 0);
      send(0, 0, 0, 0, a);   collect(a, 0);
      send(0, 0, 0, 0, a);   collect(a, 0);

      // Write together with an accept only affects the next sample.
      send(3, 1, 0, 2, a); collect(a, 0);
      send(5, 0, 0, 0, a); collect(a, 0);

      // Positive saturation of the 16-bit output.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(32767, 0, 0, 0, a);
         collect(a, 0);
      end

      // Negative boundary: exact minimum, then clipped.
      do_reset();
      send(-32768, 0, 0, 0, a); collect(a, 0);
      send(-32768, 0, 0, 0, a); collect(a, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
